// File: rtl/urv_ecc.sv
// SEC-DED (39,32) extended-Hamming encoder and checker for the uRV register file,
// with optional correction path and saturating corrected/uncorrectable error counters.
module urv_ecc #(
  parameter int g_with_check = 1,
  parameter int g_cnt_width  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [31:0]            dat_i,
  output logic [6:0]             ecc_o,
  input  logic                   chk_valid_i,
  input  logic [31:0]            chk_dat_i,
  input  logic [6:0]             chk_ecc_i,
  output logic [31:0]            cor_dat_o,
  output logic [5:0]             syndrome_o,
  output logic                   sec_o,
  output logic                   ded_o,
  input  logic                   clr_i,
  output logic [g_cnt_width-1:0] sec_cnt_o,
  output logic [g_cnt_width-1:0] ded_cnt_o
);

  // Codeword position of data bit j: skip the power-of-two check positions.
  function automatic logic [5:0] data_pos(input int j);
    int p;
    if (j < 1)       p = 3;
    else if (j < 4)  p = j + 4;
    else if (j < 11) p = j + 5;
    else if (j < 26) p = j + 6;
    else             p = j + 7;
    return p[5:0];
  endfunction

  // XOR-ing the positions of all set data bits yields the six Hamming check bits.
  function automatic logic [6:0] ecc_calc(input logic [31:0] d);
    logic [5:0] c;
    c = '0;
    for (int j = 0; j < 32; j++)
      if (d[j]) c = c ^ data_pos(j);
    return {(^d) ^ (^c), c};
  endfunction

  assign ecc_o = ecc_calc(dat_i);

  generate
    if (g_with_check != 0) begin : g_check
      logic [5:0]             s;
      logic                   p;
      logic [6:0]             chk_enc;
      logic [g_cnt_width-1:0] sec_cnt_q;
      logic [g_cnt_width-1:0] ded_cnt_q;

      localparam logic [g_cnt_width-1:0] CNT_ONE = {{(g_cnt_width-1){1'b0}}, 1'b1};

      assign chk_enc    = ecc_calc(chk_dat_i);
      assign s          = chk_enc[5:0] ^ chk_ecc_i[5:0];
      assign p          = (^chk_dat_i) ^ (^chk_ecc_i);
      assign syndrome_o = s;

      // Odd parity with an in-range syndrome is a single error; everything else nonzero is uncorrectable.
      assign sec_o = p && (s <= 6'd38);
      assign ded_o = (p && (s > 6'd38)) || (!p && (s != 6'd0));

      always_comb begin
        cor_dat_o = chk_dat_i;
        if (sec_o)
          for (int j = 0; j < 32; j++)
            if (data_pos(j) == s) cor_dat_o[j] = ~chk_dat_i[j];
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          sec_cnt_q <= '0;
          ded_cnt_q <= '0;
        end else if (clr_i) begin
          sec_cnt_q <= '0;
          ded_cnt_q <= '0;
        end else if (chk_valid_i) begin
          if (sec_o && !(&sec_cnt_q)) sec_cnt_q <= sec_cnt_q + CNT_ONE;
          if (ded_o && !(&ded_cnt_q)) ded_cnt_q <= ded_cnt_q + CNT_ONE;
        end
      end

      assign sec_cnt_o = sec_cnt_q;
      assign ded_cnt_o = ded_cnt_q;
    end else begin : g_no_check
      assign cor_dat_o  = '0;
      assign syndrome_o = '0;
      assign sec_o      = 1'b0;
      assign ded_o      = 1'b0;
      assign sec_cnt_o  = '0;
      assign ded_cnt_o  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_urv_ecc.sv
// Directed self-checking bench for urv_ecc: encoder vectors, single/double error
// classification, correction sweeps and the saturating error counters.
module tb_urv_ecc;

  logic        clk;
  logic        rst_n;
  logic [31:0] dat;
  logic [6:0]  ecc;
  logic        chk_valid;
  logic [31:0] chk_dat;
  logic [6:0]  chk_ecc;
  logic [31:0] cor_dat;
  logic [5:0]  syndrome;
  logic        sec;
  logic        ded;
  logic        clr;
  logic [15:0] sec_cnt;
  logic [15:0] ded_cnt;

  logic [6:0]  sat_ecc;
  logic [31:0] sat_cor_dat;
  logic [5:0]  sat_syndrome;
  logic        sat_sec;
  logic        sat_ded;
  logic [1:0]  sat_sec_cnt;
  logic [1:0]  sat_ded_cnt;

  int checks = 0;
  int errors = 0;

  urv_ecc dut (
    .clk_i(clk), .rst_n_i(rst_n), .dat_i(dat), .ecc_o(ecc),
    .chk_valid_i(chk_valid), .chk_dat_i(chk_dat), .chk_ecc_i(chk_ecc),
    .cor_dat_o(cor_dat), .syndrome_o(syndrome), .sec_o(sec), .ded_o(ded),
    .clr_i(clr), .sec_cnt_o(sec_cnt), .ded_cnt_o(ded_cnt)
  );

  urv_ecc #(.g_with_check(1), .g_cnt_width(2)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .dat_i(dat), .ecc_o(sat_ecc),
    .chk_valid_i(chk_valid), .chk_dat_i(chk_dat), .chk_ecc_i(chk_ecc),
    .cor_dat_o(sat_cor_dat), .syndrome_o(sat_syndrome), .sec_o(sat_sec), .ded_o(sat_ded),
    .clr_i(clr), .sec_cnt_o(sat_sec_cnt), .ded_cnt_o(sat_ded_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference encoder built by walking codeword positions, independent of the design's formulation.
  function automatic logic [6:0] model_ecc(input logic [31:0] d);
    logic [6:0] e;
    int idx;
    e = '0;
    idx = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        for (int k = 0; k < 6; k++)
          if (((pos >> k) & 1) == 1) e[k] = e[k] ^ d[idx];
        idx++;
      end
    end
    e[6] = (^d) ^ (^e[5:0]);
    return e;
  endfunction

  task automatic apply_check(input logic [31:0] d, input logic [6:0] e);
    chk_dat = d;
    chk_ecc = e;
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] word;
    logic [6:0]  word_ecc;

    rst_n = 1'b0; dat = '0; chk_valid = 1'b0; chk_dat = '0; chk_ecc = '0; clr = 1'b0;
    #1;

    dat = 32'h0000_0000; #1; check_output("enc_zero", ecc, 7'h00);
    dat = 32'h0000_0001; #1; check_output("enc_one", ecc, 7'h43);
    dat = 32'hFFFF_FFFF; #1; check_output("enc_ones", ecc, 7'h18);
    dat = 32'hDEAD_BEEF; #1; check_output("enc_model", ecc, {57'd0, model_ecc(32'hDEAD_BEEF)});

    apply_check(32'h0000_0001, 7'h43);
    check_output("clean_syn", syndrome, 6'd0);
    check_output("clean_sec", sec, 1'b0);
    check_output("clean_ded", ded, 1'b0);
    check_output("clean_cor", cor_dat, 32'h0000_0001);

    apply_check(32'h0000_0001, 7'h00);
    check_output("d0_syn", syndrome, 6'd3);
    check_output("d0_sec", sec, 1'b1);
    check_output("d0_ded", ded, 1'b0);
    check_output("d0_cor", cor_dat, 32'h0000_0000);

    apply_check(32'h0000_0003, 7'h00);
    check_output("dbl_syn", syndrome, 6'd6);
    check_output("dbl_ded", ded, 1'b1);
    check_output("dbl_sec", sec, 1'b0);
    check_output("dbl_cor", cor_dat, 32'h0000_0003);

    apply_check(32'h0000_0001, 7'h03);
    check_output("p6_syn", syndrome, 6'd0);
    check_output("p6_sec", sec, 1'b1);
    check_output("p6_cor", cor_dat, 32'h0000_0001);

    apply_check(32'h0000_0000, 7'h7F);
    check_output("inv_syn", syndrome, 6'd63);
    check_output("inv_ded", ded, 1'b1);
    check_output("inv_sec", sec, 1'b0);
    check_output("inv_cor", cor_dat, 32'h0000_0000);

    for (int w = 0; w < 3; w++) begin
      word = (w == 0) ? 32'hA5A5_5A5A : $urandom;
      word_ecc = model_ecc(word);
      for (int b = 0; b < 32; b++) begin
        apply_check(word ^ (32'd1 << b), word_ecc);
        check_output($sformatf("dflip%0d_cor", b), cor_dat, word);
        check_output($sformatf("dflip%0d_sec", b), {sec, ded}, 2'b10);
      end
      for (int b = 0; b < 7; b++) begin
        apply_check(word, word_ecc ^ (7'd1 << b));
        check_output($sformatf("eflip%0d_cor", b), cor_dat, word);
        check_output($sformatf("eflip%0d_sec", b), {sec, ded}, 2'b10);
      end
    end

    tick(1);
    check_output("rst_sec_cnt", sec_cnt, 16'd0);
    check_output("rst_ded_cnt", ded_cnt, 16'd0);
    check_output("rst_sat_sec", sat_sec_cnt, 2'd0);
    rst_n = 1'b1;

    chk_dat = 32'h0000_0001; chk_ecc = 7'h00; chk_valid = 1'b1;
    tick(4);
    chk_valid = 1'b0;
    tick(1);
    check_output("sec_cnt4", sec_cnt, 16'd4);
    check_output("ded_cnt0", ded_cnt, 16'd0);
    check_output("sat_sec3", sat_sec_cnt, 2'd3);

    chk_dat = 32'h0000_0003; chk_ecc = 7'h00; chk_valid = 1'b1;
    tick(1);
    check_output("ded_cnt1", ded_cnt, 16'd1);
    check_output("sec_hold4", sec_cnt, 16'd4);
    check_output("sat_ded1", sat_ded_cnt, 2'd1);

    chk_dat = 32'h0000_0001; chk_ecc = 7'h00;
    tick(2);
    check_output("sec_cnt6", sec_cnt, 16'd6);
    check_output("sat_sec_hold", sat_sec_cnt, 2'd3);

    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check_output("clr_sec", sec_cnt, 16'd0);
    check_output("clr_ded", ded_cnt, 16'd0);
    check_output("clr_sat_sec", sat_sec_cnt, 2'd0);

    tick(2);
    check_output("sec_cnt2", sec_cnt, 16'd2);
    check_output("sat_sec2", sat_sec_cnt, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_sec", sec_cnt, 16'd0);
    check_output("async_rst_sat", sat_sec_cnt, 2'd0);
    chk_valid = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
